mr_wb_arb: RTL and testbench

- Writeback arbiter that shares the single register-file write port (wb_valid/wb_reg/wb_val) and the jmp_done strobe of the decode stage between two producers: the ALU result path and the memory load-return path.
- Each source has a 1-entry holding register.
- Arbitration is age-ordered with a starvation limit.
- Outputs are registered and feed the decode stage's regfile and pending-write scoreboard directly.

---
 rtl/mr_wb_arb_pkg.sv | 25 ++
 rtl/mr_wb_slot.sv | 37 +++
 rtl/mr_wb_arb.sv | 167 ++++++++++++++++
 tb/tb_mr_wb_arb.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mr_wb_arb_pkg.sv
// Shared writeback types: source tags and the holding-entry bundle.
// Reused by the arbiter and by the LSU/MEM stages.
package mr_wb_arb_pkg;

  localparam int WB_XLEN        = 32;
  localparam int WB_REGSEL_BITS = 5;

  typedef enum logic [1:0] {
    WBSRC_NONE = 2'd0,
    WBSRC_ALU  = 2'd1,
    WBSRC_MEM  = 2'd2
  } e_wb_src;

  typedef struct packed {
    logic [WB_REGSEL_BITS-1:0] rd;
    logic [WB_XLEN-1:0]        val;
    logic                      jmp;
  } wb_entry_t;

  // x0 is hardwired; such entries never strobe the regfile
  function automatic logic wb_writes_rf(input wb_entry_t e);
    return e.rd != '0;
  endfunction

endpackage

// File: rtl/mr_wb_slot.sv
// One-entry writeback holding register with capture/clear/ready.
// Ready depends only on registered state and the grant.
module mr_wb_slot
  import mr_wb_arb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      valid,
  input  logic      grant,
  input  wb_entry_t din,
  output logic      ready,
  output logic      full,
  output logic      full_nxt,
  output logic      cap_new,
  output wb_entry_t q
);

  logic capture;

  assign ready    = !full | grant;
  assign capture  = valid & ready;
  assign cap_new  = valid & !full;
  assign full_nxt = capture | (full & !grant);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      q    <= '0;
    end else begin
      full <= full_nxt;
      if (capture) begin
        q <= din;
      end
    end
  end

endmodule

// File: rtl/mr_wb_arb.sv
// Writeback arbiter: ALU vs load-return onto the single regfile port.
// Optional MR_WB_PERF_EN adds conflict / forced-grant counters.
module mr_wb_arb
  import mr_wb_arb_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REGSEL_BITS = 5,
  parameter int STARVE_MAX  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_wb_valid,
  output logic                   alu_wb_ready,
  input  logic [REGSEL_BITS-1:0] alu_wb_reg,
  input  logic [XLEN-1:0]        alu_wb_val,
  input  logic                   alu_wb_jmp,
  input  logic                   mem_wb_valid,
  output logic                   mem_wb_ready,
  input  logic [REGSEL_BITS-1:0] mem_wb_reg,
  input  logic [XLEN-1:0]        mem_wb_val,
  output logic                   wb_valid,
  output logic [REGSEL_BITS-1:0] wb_reg,
  output logic [XLEN-1:0]        wb_val,
  output logic                   jmp_done
`ifdef MR_WB_PERF_EN
  ,
  output logic [31:0]            perf_conflict_cnt,
  output logic [31:0]            perf_starve_cnt
`endif
);

  localparam int SW =
    (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  wb_entry_t alu_in;
  wb_entry_t mem_in;
  wb_entry_t alu_q;
  wb_entry_t mem_q;
  wb_entry_t win;
  e_wb_src   sel;

  logic alu_full;
  logic mem_full;
  logic alu_full_nxt;
  logic mem_full_nxt;
  logic alu_new;
  logic mem_new;
  logic grant_alu;
  logic grant_mem;
  logic force_alu;
  logic alu_older;
  logic [SW-1:0] starve;

  assign alu_in = '{rd: alu_wb_reg,
                    val: alu_wb_val,
                    jmp: alu_wb_jmp};
  assign mem_in = '{rd: mem_wb_reg,
                    val: mem_wb_val,
                    jmp: 1'b0};

  mr_wb_slot u_alu_slot (
    .clk      (clk),
    .rst      (rst),
    .valid    (alu_wb_valid),
    .grant    (grant_alu),
    .din      (alu_in),
    .ready    (alu_wb_ready),
    .full     (alu_full),
    .full_nxt (alu_full_nxt),
    .cap_new  (alu_new),
    .q        (alu_q)
  );

  mr_wb_slot u_mem_slot (
    .clk      (clk),
    .rst      (rst),
    .valid    (mem_wb_valid),
    .grant    (grant_mem),
    .din      (mem_in),
    .ready    (mem_wb_ready),
    .full     (mem_full),
    .full_nxt (mem_full_nxt),
    .cap_new  (mem_new),
    .q        (mem_q)
  );

  // Same destination never reorders: keeps the older write first
  assign force_alu = alu_full && mem_full
                  && (starve == STARVE_LIM)
                  && (alu_q.rd != mem_q.rd);

  assign grant_alu = alu_full
                  && (!mem_full || alu_older || force_alu);
  assign grant_mem = mem_full && !grant_alu;

  always_comb begin
    sel = WBSRC_NONE;
    win = '0;
    unique case (1'b1)
      grant_alu: begin
        sel = WBSRC_ALU;
        win = alu_q;
      end
      grant_mem: begin
        sel = WBSRC_MEM;
        win = mem_q;
      end
      default: ;
    endcase
  end

  // Age tracks fresh arrivals only; a refill keeps its slot's age
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_older <= 1'b0;
    end else if (alu_new && mem_full_nxt) begin
      alu_older <= 1'b0;
    end else if (mem_new && alu_full_nxt) begin
      alu_older <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve <= '0;
    end else if (grant_alu || !alu_full) begin
      starve <= '0;
    end else if (grant_mem && starve != STARVE_LIM) begin
      starve <= starve + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_reg   <= '0;
      wb_val   <= '0;
      jmp_done <= 1'b0;
    end else begin
      wb_valid <= (sel != WBSRC_NONE)
               && wb_writes_rf(win);
      jmp_done <= (sel == WBSRC_ALU) && win.jmp;
      if (sel != WBSRC_NONE && wb_writes_rf(win)) begin
        wb_reg <= win.rd;
        wb_val <= win.val;
      end
    end
  end

`ifdef MR_WB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_conflict_cnt <= '0;
      perf_starve_cnt   <= '0;
    end else begin
      if (alu_full && mem_full) begin
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      end
      if (force_alu) begin
        perf_starve_cnt <= perf_starve_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mr_wb_arb.sv
// Scoreboard bench for mr_wb_arb (per-source expected queues).
// Builds with or without MR_WB_PERF_EN.
module tb_mr_wb_arb;
  import mr_wb_arb_pkg::*;

  typedef struct packed {
    logic        w;
    logic        j;
    logic [4:0]  r;
    logic [31:0] v;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_wb_valid = 1'b0;
  logic        alu_wb_ready;
  logic [4:0]  alu_wb_reg = '0;
  logic [31:0] alu_wb_val = '0;
  logic        alu_wb_jmp = 1'b0;
  logic        mem_wb_valid = 1'b0;
  logic        mem_wb_ready;
  logic [4:0]  mem_wb_reg = '0;
  logic [31:0] mem_wb_val = '0;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_val;
  logic        jmp_done;
`ifdef MR_WB_PERF_EN
  logic [31:0] perf_conflict_cnt;
  logic [31:0] perf_starve_cnt;
`endif

  ev_t     exp_alu[$];
  ev_t     exp_mem[$];
  e_wb_src log_q[$];
  logic [31:0] rf [32];
  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  bit sb_en = 1'b1;

  always #5 clk = ~clk;

  mr_wb_arb dut (
    .clk          (clk),
    .rst          (rst),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_ready (alu_wb_ready),
    .alu_wb_reg   (alu_wb_reg),
    .alu_wb_val   (alu_wb_val),
    .alu_wb_jmp   (alu_wb_jmp),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_ready (mem_wb_ready),
    .mem_wb_reg   (mem_wb_reg),
    .mem_wb_val   (mem_wb_val),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .wb_val       (wb_val),
    .jmp_done     (jmp_done)
`ifdef MR_WB_PERF_EN
    ,
    .perf_conflict_cnt (perf_conflict_cnt),
    .perf_starve_cnt   (perf_starve_cnt)
`endif
  );

  function automatic bit ev_match(ev_t e, ev_t o);
    return e.w == o.w && e.j == o.j
        && (!e.w || (e.r == o.r && e.v == o.v));
  endfunction

  always @(negedge clk) begin
    ev_t o;
    if (rst && sb_en && (wb_valid || jmp_done)) begin
      o = '{w: wb_valid, j: jmp_done, r: wb_reg, v: wb_val};
      checks++;
      if (exp_alu.size() > 0 && ev_match(exp_alu[0], o)) begin
        void'(exp_alu.pop_front());
        log_q.push_back(WBSRC_ALU);
      end else if (exp_mem.size() > 0
                   && ev_match(exp_mem[0], o)) begin
        void'(exp_mem.pop_front());
        log_q.push_back(WBSRC_MEM);
      end else begin
        failures++;
        $display("FAIL wb_event got w=%0b j=%0b reg=%0d val=%h, required a queued ALU/MEM entry",
                 o.w, o.j, o.r, o.v);
      end
    end
    if (rst && wb_valid) begin
      rf[wb_reg] = wb_val;
      wr_cnt++;
    end
  end

  task automatic alu_send(input logic [4:0] r,
                          input logic [31:0] v,
                          input logic j);
    logic acc;
    acc = 1'b0;
    alu_wb_valid = 1'b1;
    alu_wb_reg = r;
    alu_wb_val = v;
    alu_wb_jmp = j;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      acc = alu_wb_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    alu_wb_valid = 1'b0;
    if (!acc) begin
      failures++;
      $display("FAIL alu_send_timeout got ready=0 required ready=1");
    end else if (r != 0 || j) begin
      exp_alu.push_back('{w: r != 0, j: j, r: r, v: v});
    end
  endtask

  task automatic mem_send(input logic [4:0] r,
                          input logic [31:0] v);
    logic acc;
    acc = 1'b0;
    mem_wb_valid = 1'b1;
    mem_wb_reg = r;
    mem_wb_val = v;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      acc = mem_wb_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    mem_wb_valid = 1'b0;
    if (!acc) begin
      failures++;
      $display("FAIL mem_send_timeout got ready=0 required ready=1");
    end else if (r != 0) begin
      exp_mem.push_back('{w: 1'b1, j: 1'b0, r: r, v: v});
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({wb_valid, jmp_done, wb_reg, wb_val} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b j=%b r=%0d d=%h required all 0",
               wb_valid, jmp_done, wb_reg, wb_val);
    end
    checks++;
    if ({alu_wb_ready, mem_wb_ready} !== 2'b11) begin
      failures++;
      $display("FAIL reset_ready got %b%b required 11",
               alu_wb_ready, mem_wb_ready);
    end
    rst = 1'b1;
    settle();
  endtask

  task automatic test_alu_only();
    alu_send(5'd5, 32'h11, 1'b0);
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || alu_wb_ready !== 1'b1) begin
      failures++;
      $display("FAIL alu_only_c1 got v=%b rdy=%b required v=0 rdy=1",
               wb_valid, alu_wb_ready);
    end
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || wb_reg !== 5'd5
        || wb_val !== 32'h11 || alu_wb_ready !== 1'b1) begin
      failures++;
      $display("FAIL alu_only_c2 got v=%b r=%0d d=%h rdy=%b required v=1 r=5 d=11 rdy=1",
               wb_valid, wb_reg, wb_val, alu_wb_ready);
    end
    settle();
  endtask

  task automatic test_same_reg();
    log_q.delete();
    fork
      alu_send(5'd3, 32'hA, 1'b0);
      mem_send(5'd3, 32'hB);
    join
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (log_q.size() != 2 || log_q[0] != WBSRC_MEM
        || log_q[1] != WBSRC_ALU) begin
      failures++;
      $display("FAIL same_reg_order got n=%0d first=%0d required n=2 MEM then ALU",
               log_q.size(), log_q.size() > 0 ? int'(log_q[0]) : -1);
    end
    checks++;
    if (rf[3] !== 32'hA) begin
      failures++;
      $display("FAIL same_reg_x3 got %h required 0000000a", rf[3]);
    end
    settle();
  endtask

  task automatic test_starve();
`ifdef MR_WB_PERF_EN
    logic [31:0] p0;
    p0 = perf_starve_cnt;
`endif
    log_q.delete();
    fork
      begin
        for (int i = 1; i <= 8; i++)
          mem_send(5'(i), 32'h300 + i);
      end
      alu_send(5'd9, 32'h900, 1'b0);
    join
    repeat (8) @(negedge clk);
    #1;
    checks++;
    if (log_q.size() != 9) begin
      failures++;
      $display("FAIL starve_count got %0d required 9",
               log_q.size());
    end
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] != (i == 3 ? WBSRC_ALU : WBSRC_MEM)) begin
        failures++;
        $display("FAIL starve_order[%0d] got src=%0d required %0d",
                 i, int'(log_q[i]), i == 3 ? 1 : 2);
      end
    end
    checks++;
    if (rf[9] !== 32'h900) begin
      failures++;
      $display("FAIL starve_x9 got %h required 00000900", rf[9]);
    end
`ifdef MR_WB_PERF_EN
    checks++;
    if (perf_starve_cnt - p0 !== 32'd1) begin
      failures++;
      $display("FAIL perf_starve got %0d required 1",
               perf_starve_cnt - p0);
    end
`endif
    settle();
  endtask

  task automatic test_jmp();
    logic [4:0]  pr;
    logic [31:0] pv;
    pr = wb_reg;
    pv = wb_val;
    alu_send(5'd0, 32'h55, 1'b1);
    @(negedge clk);
    checks++;
    if (jmp_done !== 1'b0) begin
      failures++;
      $display("FAIL jmp0_c1 got %b required 0", jmp_done);
    end
    @(negedge clk);
    checks++;
    if (jmp_done !== 1'b1 || wb_valid !== 1'b0
        || wb_reg !== pr || wb_val !== pv) begin
      failures++;
      $display("FAIL jmp0_c2 got j=%b v=%b r=%0d d=%h required j=1 v=0 r=%0d d=%h",
               jmp_done, wb_valid, wb_reg, wb_val, pr, pv);
    end
    @(negedge clk);
    checks++;
    if (jmp_done !== 1'b0) begin
      failures++;
      $display("FAIL jmp0_c3 got %b required 0", jmp_done);
    end
    @(posedge clk);
    #1;
    alu_send(5'd1, 32'h66, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (jmp_done !== 1'b1 || wb_valid !== 1'b1
        || wb_reg !== 5'd1 || wb_val !== 32'h66) begin
      failures++;
      $display("FAIL jmp1 got j=%b v=%b r=%0d d=%h required j=1 v=1 r=1 d=66",
               jmp_done, wb_valid, wb_reg, wb_val);
    end
    settle();
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = wr_cnt;
    fork
      begin
        for (int i = 0; i < 20; i++)
          alu_send(5'((i % 31) + 1), 32'hA000 + i, 1'b0);
      end
      begin
        for (int i = 0; i < 20; i++)
          mem_send(5'(((i + 7) % 31) + 1), 32'hB000 + i);
      end
    join
    for (int n = 0; n < 100; n++) begin
      if (exp_alu.size() == 0 && exp_mem.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_alu.size() != 0 || exp_mem.size() != 0) begin
      failures++;
      $display("FAIL stream_drain got alu=%0d mem=%0d left required 0",
               exp_alu.size(), exp_mem.size());
    end
    checks++;
    if (wr_cnt - w0 != 40) begin
      failures++;
      $display("FAIL stream_writes got %0d required 40",
               wr_cnt - w0);
    end
    settle();
  endtask

  task automatic test_async_reset();
    int w0;
    sb_en = 1'b0;
    alu_wb_valid = 1'b1;
    alu_wb_reg = 5'd7;
    alu_wb_val = 32'h77;
    alu_wb_jmp = 1'b0;
    mem_wb_valid = 1'b1;
    mem_wb_reg = 5'd8;
    mem_wb_val = 32'h88;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || wb_reg !== 5'd8) begin
      failures++;
      $display("FAIL arst_pre got v=%b r=%0d required v=1 r=8",
               wb_valid, wb_reg);
    end
    alu_wb_valid = 1'b0;
    #1;
    checks++;
    if (alu_wb_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_comb_lo got %b required 0",
               alu_wb_ready);
    end
    alu_wb_valid = 1'b1;
    #1;
    checks++;
    if (alu_wb_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_comb_hi got %b required 0",
               alu_wb_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({wb_valid, jmp_done, wb_reg, wb_val} !== '0) begin
      failures++;
      $display("FAIL arst_outputs got v=%b j=%b r=%0d d=%h required all 0",
               wb_valid, jmp_done, wb_reg, wb_val);
    end
    alu_wb_valid = 1'b0;
    mem_wb_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sb_en = 1'b1;
    w0 = wr_cnt;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (wr_cnt != w0 || wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL arst_stale got writes=%0d v=%b required 0 and 0",
               wr_cnt - w0, wb_valid);
    end
    checks++;
    if ({alu_wb_ready, mem_wb_ready} !== 2'b11) begin
      failures++;
      $display("FAIL arst_ready got %b%b required 11",
               alu_wb_ready, mem_wb_ready);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    test_reset();
    test_alu_only();
    test_same_reg();
    test_starve();
    test_jmp();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (exp_alu.size() != 0 || exp_mem.size() != 0) begin
      failures++;
      $display("FAIL final_queues got alu=%0d mem=%0d required 0",
               exp_alu.size(), exp_mem.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
